// File: rtl/serial_twos_comp_deserializer_pkg.sv
// Shared encodings for the serial two's-complement receive path.
// Holds the converter state names and a helper for the most-negative word.
package serial_twos_comp_deserializer_pkg;

    // IDLE is the frame-level view; the converter cell only uses COPY/INVERT.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COPY   = 2'd1,
        ST_INVERT = 2'd2
    } conv_state_e;

    localparam int MAX_WIDTH = 64;

    // Pattern 1 followed by w-1 zeros: the value whose negation cannot be represented.
    function automatic logic [MAX_WIDTH-1:0] most_neg(input int w);
        logic [MAX_WIDTH-1:0] p;
        p = '0;
        p[w-1] = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/serial_twos_comp_deserializer_cell.sv
// Bit-serial COPY/INVERT converter (LSB-first two's-complement negation).
// Passes bits through until the first 1, then inverts every following bit.
module serial_comp_cell
    import serial_twos_comp_deserializer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic active_i,
    input  logic bit_i,
    output logic bit_o
);

    conv_state_e state_q;
    conv_state_e state_d;
    conv_state_e cur;

    // A clear (new frame) or an idle frame forces COPY for the current bit.
    always_comb begin
        cur     = state_q;
        state_d = state_q;
        if (clr_i || !active_i) begin
            cur = ST_COPY;
        end
        bit_o = (cur == ST_INVERT) ? ~bit_i : bit_i;
        if (en_i && (clr_i || active_i)) begin
            if (cur == ST_INVERT || bit_i) begin
                state_d = ST_INVERT;
            end else begin
                state_d = ST_COPY;
            end
        end
    end

    // Converter state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_COPY;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/serial_twos_comp_deserializer.sv
// Receive end of the serial two's-complement link.
// Re-complements an LSB-first stream and assembles WIDTH-bit words.
module serial_twos_comp_deserializer
    import serial_twos_comp_deserializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frameStart,
    input  logic             bitValid,
    input  logic             bitIn,
    output logic             bitOut,
    output logic [WIDTH-1:0] wordOut,
    output logic             wordValid,
    output logic             negative,
    output logic             overflow,
    output logic             frameErr
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [MAX_WIDTH-1:0] MN_FULL = most_neg(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = MN_FULL[WIDTH-1:0];

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             wvalid_q, wvalid_d;
    logic             ferr_q, ferr_d;
    logic [WIDTH-1:0] next_word;

    serial_comp_cell u_cell (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (frameStart),
        .en_i     (bitValid),
        .active_i (busy_q),
        .bit_i    (bitIn),
        .bit_o    (bitOut)
    );

    assign next_word = {bitOut, shift_q[WIDTH-1:1]};

    // Frame sequencing: start/abort, bit counting, word completion.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        word_d   = word_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        wvalid_d = 1'b0;
        ferr_d   = 1'b0;
        if (bitValid && frameStart) begin
            // An in-progress frame is dropped; this bit becomes bit 0.
            busy_d  = 1'b1;
            cnt_d   = ONE;
            shift_d = {bitOut, {(WIDTH-1){1'b0}}};
            ferr_d  = busy_q;
        end else if (bitValid && busy_q) begin
            shift_d = next_word;
            if (cnt_q == LAST) begin
                busy_d   = 1'b0;
                cnt_d    = '0;
                word_d   = next_word;
                neg_d    = next_word[WIDTH-1];
                ovf_d    = (next_word == MOST_NEG);
                wvalid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            word_q   <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            wvalid_q <= wvalid_d;
            ferr_q   <= ferr_d;
        end
    end

    assign wordOut   = word_q;
    assign wordValid = wvalid_q;
    assign negative  = neg_q;
    assign overflow  = ovf_q;
    assign frameErr  = ferr_q;

endmodule

// File: doc/serial_twos_comp_deserializer.md
Name: serial_twos_comp_deserializer

Overview:
Receive end of the serial two's-complement link. Accepts an LSB-first bitstream that is already complemented (the negated operand), re-complements it on the fly, and assembles it into a WIDTH-bit parallel word. Presents the word with a one-cycle valid pulse and sign/overflow flags. Sits after the serial complementer stage and feeds parallel datapath logic.

Parameters:
WIDTH, 8, bits per frame (word width), minimum 2

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
frameStart  input  1  qualifies the current bit as bit 0 (LSB) of a new frame; only meaningful with bitValid=1
bitValid  input  1  bitIn is sampled this cycle when high
bitIn  input  1  serial data, LSB first
bitOut  output  1  recovered (re-complemented) bit for the current sampled input, combinational Mealy output
wordOut  output  WIDTH  last completed recovered word, held until next completion
wordValid  output  1  one-cycle pulse when wordOut updates
negative  output  1  wordOut[WIDTH-1], registered alongside wordOut
overflow  output  1  high when wordOut == 1 followed by WIDTH-1 zeros (most-negative value, negation not representable); registered alongside wordOut
frameErr  output  1  one-cycle pulse when a frame is aborted by an early frameStart

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, bit counter=0, shift register=0, wordOut=0, wordValid=0, negative=0, overflow=0, frameErr=0. Applies mid-frame; the partial frame is discarded with no wordValid and no frameErr.
- Converter states: IDLE (no frame), COPY (no 1 seen yet in frame: bitOut=bitIn), INVERT (a 1 has been seen: bitOut=~bitIn).
- IDLE: bitValid&frameStart starts a frame with this bit as bit 0. Otherwise bits are ignored and bitOut=bitIn.
- bitValid & frameStart: the converter is treated as COPY for this bit regardless of current state. Next state is INVERT if bitIn=1, else COPY. Counter=1.
- bitValid & !frameStart in COPY/INVERT: the bit is converted per the current state. COPY moves to INVERT on bitIn=1. Counter increments.
- bitValid=0: no state, counter or shift change; gaps of any length are allowed mid-frame.
- Shift register: each accepted bit shifts right with bitOut entering the MSB, so after WIDTH bits bit 0 sits at the LSB.
- Completion: when the WIDTH-th bit is accepted, on that edge wordOut <= the assembled word (including that bit) and negative/overflow are updated. wordValid=1 for the following cycle only. State returns to IDLE and counter to 0. Latency from last bit sampled to wordValid is 1 cycle.
- Back-to-back frames: frameStart may arrive on the cycle wordValid is high. It is accepted as bit 0 of the next frame with no bubble.
- Early frameStart (counter in 1..WIDTH-1): the partial frame is discarded and frameErr pulses for one cycle after the edge. The bit is accepted as bit 0 of a new frame; wordOut is unchanged.
- Non-wrapping counter 0..WIDTH-1; it never exceeds WIDTH-1.
- bitOut is a pure function of state, frameStart, bitValid and bitIn; no registered delay.

Decomposition:
- Shared package: state encoding constants (IDLE, COPY, INVERT) and a function returning the most-negative pattern for WIDTH.
- One sub-module: serial_comp_cell. It is the 2-state COPY/INVERT Mealy converter with a synchronous clear input (driven by frameStart) and an enable (bitValid). The top level holds the counter, shift register and output registers.

Test Plan (WIDTH=8):
- Reset, then frame stream 1,1,0,1,1,1,1,1 (−5) with bitValid=1 -> wordOut=0x05, negative=0, overflow=0, wordValid high exactly one cycle after the 8th bit.
- Stream 1,0,0,0,0,0,0,0 -> wordOut=0xFF, negative=1, overflow=0. Stream of eight 0s -> wordOut=0x00, bitOut=0 throughout.
- Stream 0,0,0,0,0,0,0,1 -> wordOut=0x80, negative=1, overflow=1.
- Same −5 stream with bitValid low for 3 cycles after bits 2 and 5 -> wordOut=0x05, wordValid delayed by 6 cycles, no spurious pulses.
- Start a frame, assert frameStart at bit 4 -> frameErr pulse, wordOut keeps its old value. Completing the new frame of −5 -> 0x05. Back-to-back second frame with frameStart on the wordValid cycle -> second word valid 8 cycles later.
- rst=0 at bit 5 of a frame -> all outputs 0, no wordValid. A following full frame decodes correctly.
